// File: rtl/apb4_slave_wait_mem_pkg.sv
// apb4_mem_pkg: shared FSM state type, error-cause encoding and lane-alignment helper
// for the APB4 wait-state slave memory. No ports.
package apb4_mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef logic [2:0] err_t;
    localparam err_t ERR_NONE  = 3'b000;
    localparam err_t ERR_ALIGN = 3'b001;
    localparam err_t ERR_RANGE = 3'b010;
    localparam err_t ERR_PROT  = 3'b100;
    function automatic int align_bits(input int dw);
        return dw == 64 ? 3 : dw == 32 ? 2 : dw == 16 ? 1 : 0;
    endfunction
endpackage

// File: rtl/apb4_slave_wait_mem_if.sv
// apb4_slave_wait_mem_if: APB4 bus bundle.
// master drives psel/penable/pwrite/paddr/pwdata/pstrb/pprot; slave drives prdata/pready/pslverr.
interface apb4_slave_wait_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;
    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb4_slave_wait_mem_array.sv
// apb4_mem_array: DEPTH x DATA_WIDTH storage with synchronous clear,
// byte-enabled write port and one asynchronous read port.
// clk/clr: clock and clear-all; we/widx/wstrb/wdata: write port; ridx/rdata: read port.
module apb4_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int IW         = 10
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    we,
    input  logic [IW-1:0]           widx,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [IW-1:0]           ridx,
    output logic [DATA_WIDTH-1:0]   rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++)
                if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end
    assign rdata = mem[ridx];
endmodule

// File: rtl/apb4_slave_wait_mem.sv
// apb4_slave_wait_mem: APB4 slave memory with programmable wait states, byte-lane
// writes, privileged-word write protection and PSLVERR on bad accesses.
// PCLK/PRESETn: clock and synchronous active-low reset; apb: APB4 slave bus.
module apb4_slave_wait_mem
    import apb4_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int PRIV_WORDS  = 0
) (
    input  logic PCLK,
    input  logic PRESETn,
    apb4_slave_wait_mem_if.slave apb
);
    localparam int ALIGN = align_bits(DATA_WIDTH);
    localparam int IW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
    // clamped so the comparison below never degenerates to "< 0"
    localparam int PW    = PRIV_WORDS > 0 ? PRIV_WORDS : 1;
    localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'((1 << ALIGN) - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    write_q, write_d;
    err_t                    err_q, err_d, err_in;
    logic [ADDR_WIDTH-1:0]   word;
    logic                    priv, commit;
    logic [DATA_WIDTH-1:0]   rd, prdata_q, prdata_d;
    logic                    pready_q, pready_d, pslverr_q, pslverr_d;
    logic                    unused;

    assign unused = ^apb.pprot[2:1];
    assign word   = apb.paddr >> ALIGN;
    assign priv   = PRIV_WORDS > 0 && apb.pwrite && !apb.pprot[0] && word < ADDR_WIDTH'(PW);
    assign err_in = (|(apb.paddr & AMASK) ? ERR_ALIGN : ERR_NONE)
                  | (word >= ADDR_WIDTH'(DEPTH) ? ERR_RANGE : ERR_NONE)
                  | (priv ? ERR_PROT : ERR_NONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: if (apb.psel && !apb.penable) begin
                idx_d   = word[IW-1:0];
                write_d = apb.pwrite;
                err_d   = err_in;
                cnt_d   = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
                state_d = WAIT_STATES > 0 ? WAIT : DONE;
            end
            WAIT: begin
                state_d = !apb.psel ? IDLE : cnt_q == 4'd0 ? DONE : WAIT;
                cnt_d   = apb.psel && cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
            end
            DONE: begin
                state_d = IDLE;
                commit  = apb.psel && apb.penable && write_q && err_q == ERR_NONE;
            end
            default: state_d = IDLE;
        endcase
        // DONE lasts one cycle, so entering it is the only way state_d is DONE
        pready_d  = state_d == DONE;
        pslverr_d = pready_d && err_d != ERR_NONE;
        prdata_d  = pready_d && !write_d && err_d == ERR_NONE ? rd : '0;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= ERR_NONE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;

    // read port follows idx_d so zero-wait reads see the setup-cycle address
    apb4_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IW         (IW)
    ) u_mem (
        .clk   (PCLK),
        .clr   (!PRESETn),
        .we    (commit),
        .widx  (idx_q),
        .wstrb (apb.pstrb),
        .wdata (apb.pwdata),
        .ridx  (idx_d),
        .rdata (rd)
    );
endmodule

// File: tb/tb_apb4_slave_wait_mem.sv
// tb_apb4_slave_wait_mem: directed bench for a zero-wait slave and a 3-wait, privileged, 48-word slave.
module tb_apb4_slave_wait_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  psel = 2'b00;
    logic        penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    bit          sel = 1'b0;
    logic        pready, pslverr;
    logic [31:0] prdata;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    apb4_slave_wait_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb4_slave_wait_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

    assign bus0.psel = psel[0];
    assign bus3.psel = psel[1];
    assign bus0.penable = penable;
    assign bus3.penable = penable;
    assign bus0.pwrite = pwrite;
    assign bus3.pwrite = pwrite;
    assign bus0.paddr = paddr;
    assign bus3.paddr = paddr;
    assign bus0.pwdata = pwdata;
    assign bus3.pwdata = pwdata;
    assign bus0.pstrb = pstrb;
    assign bus3.pstrb = pstrb;
    assign bus0.pprot = pprot;
    assign bus3.pprot = pprot;

    assign pready  = sel ? bus3.pready  : bus0.pready;
    assign pslverr = sel ? bus3.pslverr : bus0.pslverr;
    assign prdata  = sel ? bus3.prdata  : bus0.prdata;

    apb4_slave_wait_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0), .PRIV_WORDS(0))
        dut0 (.PCLK(clk), .PRESETn(rst_n), .apb(bus0));
    apb4_slave_wait_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(48), .WAIT_STATES(3), .PRIV_WORDS(4))
        dut3 (.PCLK(clk), .PRESETn(rst_n), .apb(bus3));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input string tag, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot,
                        input logic [31:0] exp_data, input bit exp_err, input int exp_waits);
        int waits;
        psel = sel ? 2'b10 : 2'b01;
        penable = 1'b0;
        pwrite = wr;
        paddr = addr;
        pwdata = data;
        pstrb = strb;
        pprot = prot;
        @(negedge clk);
        penable = 1'b1;
        waits = 0;
        while (!pready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check({tag, "_pready"}, pready, 1);
        check({tag, "_waits"}, waits, exp_waits);
        check({tag, "_pslverr"}, pslverr, exp_err);
        if (!wr) check({tag, "_prdata"}, prdata, exp_data);
        @(negedge clk);
        check({tag, "_pready_low"}, pready, 0);
        check({tag, "_idle_out"}, {pslverr, prdata}, 0);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot, input bit exp_err, input int exp_waits);
        xfer(tag, 1'b1, addr, data, strb, prot, 0, exp_err, exp_waits);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                      input bit exp_err, input int exp_waits);
        xfer(tag, 1'b0, addr, 0, 4'h0, 3'b000, exp_data, exp_err, exp_waits);
    endtask

    task automatic idle();
        psel = 2'b00;
        penable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst0_out", {bus0.pready, bus0.pslverr, bus0.prdata}, 0);
        check("rst3_out", {bus3.pready, bus3.pslverr, bus3.prdata}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        sel = 1'b0;
        wr("w10", 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0);
        rd("r10", 32'h10, 32'hDEADBEEF, 0, 0);
        wr("w20a", 32'h20, 32'hFFFFFFFF, 4'hF, 3'b000, 0, 0);
        wr("w20b", 32'h20, 32'h12345678, 4'h5, 3'b000, 0, 0);
        wr("w20z", 32'h20, 32'h00000000, 4'h0, 3'b000, 0, 0);
        rd("r20", 32'h20, 32'hFF34FF78, 0, 0);
        wr("wffc", 32'hFFC, 32'hCAFEF00D, 4'hF, 3'b000, 0, 0);
        rd("r13_mis", 32'h13, 32'h0, 1, 0);
        wr("w11_mis", 32'h11, 32'h0, 4'hF, 3'b000, 1, 0);
        wr("w1000_oor", 32'h1000, 32'h11111111, 4'hF, 3'b000, 1, 0);
        rd("rffc", 32'hFFC, 32'hCAFEF00D, 0, 0);
        rd("r10b", 32'h10, 32'hDEADBEEF, 0, 0);
        rd("r0", 32'h0, 32'h0, 0, 0);
        idle();

        sel = 1'b1;
        rd("ws3_r0", 32'h0, 32'h0, 0, 3);
        wr("p_w8", 32'h8, 32'hA5, 4'hF, 3'b000, 1, 3);
        rd("p_r8a", 32'h8, 32'h0, 0, 3);
        wr("p_w8p", 32'h8, 32'hA5, 4'hF, 3'b001, 0, 3);
        rd("p_r8b", 32'h8, 32'hA5, 0, 3);
        wr("p_w10", 32'h10, 32'h77, 4'hF, 3'b000, 0, 3);
        rd("p_r10", 32'h10, 32'h77, 0, 3);
        rd("oor48", 32'hC0, 32'h0, 1, 3);
        rd("rbc", 32'hBC, 32'h0, 0, 3);
        idle();

        psel = 2'b10;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h40;
        pwdata = 32'h55;
        pstrb = 4'hF;
        pprot = 3'b000;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 2'b00;
        penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_pready", pready, 0);
        end
        rd("abort_r40", 32'h40, 32'h0, 0, 3);
        idle();

        psel = 2'b10;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h44;
        pwdata = 32'h99;
        pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_pready", pready, 0);
        end
        psel = 2'b00;
        penable = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        rd("rst_r8", 32'h8, 32'h0, 0, 3);
        rd("rst_r44", 32'h44, 32'h0, 0, 3);
        sel = 1'b0;
        rd("rst_r10", 32'h10, 32'h0, 0, 0);
        rd("rst_rffc", 32'hFFC, 32'h0, 0, 0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/apb4_slave_wait_mem.md
# apb4_slave_wait_mem

Parametrised APB4 slave memory: the next-generation target that the APB4 slave VIP drives, replacing the fixed 32-bit/1024-word zero-wait slave. It adds configurable data/address width and depth, programmable wait states, PSTRB byte-lane writes, PPROT-based write protection, and PSLVERR for misaligned, out-of-range or protected accesses. It sits directly on the APB bus as the DUT under the VIP environment.

## Interface
- ADDR_WIDTH, 32, PADDR width in bits
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16, 32 or 64
- DEPTH, 1024, number of DATA_WIDTH-bit words; need not be a power of two
- WAIT_STATES, 0, PREADY-low access cycles inserted per transfer (0..15)
- PRIV_WORDS, 0, words at indices 0..PRIV_WORDS-1 writable only when PPROT[0]=1

- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  synchronous, active-low reset
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PWRITE  in  1  1=write, 0=read
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  write byte lanes
- PPROT  in  3  protection; only bit 0 (privileged) used
- PRDATA  out  DATA_WIDTH  read data, valid when PREADY=1
- PREADY  out  1  transfer completion
- PSLVERR  out  1  error, valid only when PREADY=1

## Operation
- ALIGN = log2(DATA_WIDTH/8); word index = PADDR >> ALIGN.
- Error conditions, evaluated on PADDR/PWRITE/PPROT sampled in setup: misaligned (PADDR[ALIGN-1:0] != 0), out of range (index >= DEPTH), protected write (PWRITE=1, index < PRIV_WORDS, PPROT[0]=0).
- FSM states IDLE, WAIT, DONE:
  - IDLE: PSEL=1 & PENABLE=0 sampled -> latch address/control/error; go WAIT with cnt=WAIT_STATES-1 if WAIT_STATES>0, else DONE. PENABLE=1 without prior setup ignored.
  - WAIT: cnt decrements each cycle; on cnt=0 edge go DONE.
  - DONE: PREADY=1 this cycle. On edge with PSEL&PENABLE: commit write (if no error), return IDLE.
  - Any state: PSEL=0 sampled in WAIT/DONE -> abort to IDLE, no write, outputs to idle values.
- Writes: only lanes with PSTRB[i]=1 updated; PSTRB=0 completes with no change. PWDATA/PSTRB sampled at completion edge.
- Reads: PSTRB ignored. PRDATA = word at index, loaded on the edge entering DONE; on error PRDATA=0.
- Error transfers: PSLVERR=1 with PREADY=1, memory unchanged.
- Reset: PREADY=0, PSLVERR=0, PRDATA=0, FSM IDLE, cnt=0, all memory words cleared to 0. Reset asserted mid-transfer abandons it with no write.

## Timing
- PREADY, PSLVERR, PRDATA registered; PREADY high exactly one cycle per transfer.
- Setup cycle T -> PREADY=1 in cycle T+1+WAIT_STATES; total transfer = 2+WAIT_STATES cycles.
- Write visible to a read whose setup is in the cycle after completion (back-to-back, no IDLE gap required).
- PSLVERR and PRDATA return to 0 the cycle after PREADY falls.

## Structure
- Package apb4_mem_pkg: state enum typedef (IDLE/WAIT/DONE), align_bits function, error-cause constants.
- Sub-module apb4_mem_array: DEPTH x DATA_WIDTH storage, synchronous clear, byte-enabled write port, one read port.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to 0x10, PSTRB=0xF, then read 0x10 -> PREADY in 2nd cycle each, PRDATA=0xDEADBEEF, PSLVERR=0.
- WAIT_STATES=3: read 0x0 after reset -> PREADY low 3 access cycles then high 1, PRDATA=0.
- Byte lanes: write 0xFFFFFFFF to 0x20, then 0x12345678 with PSTRB=0x5 -> read 0xFF34FF78.
- Errors: read 0x3 (misaligned), write DEPTH*4 (out of range) -> PSLVERR=1, PRDATA=0; read DEPTH*4-4 returns prior contents untouched.
- PRIV_WORDS=4: write 0xA5 to 0x8 with PPROT=0 -> PSLVERR=1, readback 0; same with PPROT=1 -> OK, readback 0xA5.
- Abort/reset: drop PSEL during WAIT of write to 0x40 -> no write (reads 0); PRESETn low mid-transfer -> PREADY=0 next cycle, memory all 0.
